// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer: REQ -> WAIT -> EXEC per instruction.
// Ports: clk/rst_n, next-PC candidates + PCSrc, stall, imem handshake,
// Instr/instr_valid to datapath, misaligned_trap/epc_out/mtval_out.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCPlus4,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic [1:0]  PCSrc,
  input  logic        stall,
  output logic [31:0] PC,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic        misaligned_trap,
  output logic [31:0] epc_out,
  output logic [31:0] mtval_out
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] cand;
  logic        cand_bad;

  // JALR target drops bit0 first, so only bit1 can fault there.
  always_comb begin
    cand = PCPlus4;
    unique case (PCSrc)
      2'b01:   cand = PCTarget;
      2'b10:   cand = ALUResult & ~32'd1;
      default: cand = PCPlus4;
    endcase
  end

  assign cand_bad = |cand[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= REQ;
      PC              <= RESET_VECTOR;
      Instr           <= 32'd0;
      instr_valid     <= 1'b0;
      imem_req_valid  <= 1'b1;
      misaligned_trap <= 1'b0;
      epc_out         <= 32'd0;
      mtval_out       <= 32'd0;
    end else begin
      misaligned_trap <= 1'b0;
      unique case (state)
        REQ: begin
          if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state       <= EXEC;
            Instr       <= imem_rdata;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            state          <= REQ;
            instr_valid    <= 1'b0;
            imem_req_valid <= 1'b1;
            if (cand_bad) begin
              PC              <= TRAP_VECTOR;
              epc_out         <= PC;
              mtval_out       <= cand;
              misaligned_trap <= 1'b1;
            end else begin
              PC <= cand;
            end
          end
        end
        default: begin
          state          <= REQ;
          instr_valid    <= 1'b0;
          imem_req_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, random instruction
// stream against a transaction-level model, and a reset-in-WAIT sequence.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCPlus4, PCTarget, ALUResult;
  logic [1:0]  PCSrc;
  logic        stall;
  logic [31:0] PC;
  logic        imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic        instr_valid, misaligned_trap;
  logic [31:0] epc_out, mtval_out;

  int checks = 0;
  int failures = 0;

  // model state
  logic [31:0] mpc, minstr, mepc, mtval;
  logic        mpend;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .PCPlus4(PCPlus4), .PCTarget(PCTarget), .ALUResult(ALUResult),
    .PCSrc(PCSrc), .stall(stall), .PC(PC),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .Instr(Instr), .instr_valid(instr_valid),
    .misaligned_trap(misaligned_trap),
    .epc_out(epc_out), .mtval_out(mtval_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_arch(input string ph);
    chk({ph, "_pc"}, PC, mpc);
    chk({ph, "_instr"}, Instr, minstr);
    chk({ph, "_epc"}, epc_out, mepc);
    chk({ph, "_mtval"}, mtval_out, mtval);
  endtask

  task automatic junk_dp();
    PCSrc     = 2'($urandom);
    PCPlus4   = $urandom;
    PCTarget  = $urandom;
    ALUResult = $urandom;
  endtask

  // One full instruction. Entered and left at a negedge with DUT in REQ.
  task automatic do_instr(input int nreq, input int nrsp, input int nstall,
                          input logic [1:0] src, input logic [31:0] p4,
                          input logic [31:0] tgt, input logic [31:0] alu,
                          input logic [31:0] word);
    logic [31:0] c;
    for (int k = 0; k <= nreq; k++) begin
      chk("req_valid_req", 32'(imem_req_valid), 32'd1);
      chk("ivalid_req", 32'(instr_valid), 32'd0);
      chk("trap_req", 32'(misaligned_trap), 32'(k == 0 && mpend));
      chk_arch("req");
      imem_req_ready = (k == nreq);
      imem_rsp_valid = 1'($urandom);
      imem_rdata     = $urandom;
      stall          = 1'($urandom);
      junk_dp();
      @(negedge clk);
    end
    mpend = 1'b0;
    for (int k = 0; k <= nrsp; k++) begin
      chk("req_valid_wait", 32'(imem_req_valid), 32'd0);
      chk("ivalid_wait", 32'(instr_valid), 32'd0);
      chk("trap_wait", 32'(misaligned_trap), 32'd0);
      chk_arch("wait");
      imem_req_ready = 1'($urandom);
      imem_rsp_valid = (k == nrsp);
      imem_rdata     = (k == nrsp) ? word : $urandom;
      stall          = 1'($urandom);
      junk_dp();
      @(negedge clk);
    end
    minstr = word;
    for (int k = 0; k <= nstall; k++) begin
      chk("req_valid_exec", 32'(imem_req_valid), 32'd0);
      chk("ivalid_exec", 32'(instr_valid), 32'd1);
      chk_arch("exec");
      imem_req_ready = 1'($urandom);
      imem_rsp_valid = 1'($urandom);
      imem_rdata     = $urandom;
      stall          = (k < nstall);
      if (k < nstall) begin
        junk_dp();
      end else begin
        PCSrc = src; PCPlus4 = p4; PCTarget = tgt; ALUResult = alu;
      end
      @(negedge clk);
    end
    if (src == 2'd1)      c = tgt;
    else if (src == 2'd2) c = alu - (alu % 2);
    else                  c = p4;
    if (c % 4 != 0) begin
      mepc  = mpc;
      mtval = c;
      mpc   = 32'h100;
      mpend = 1'b1;
    end else begin
      mpc = c;
    end
  endtask

  typedef struct {
    int          nreq, nrsp, nstall;
    logic [1:0]  src;
    logic [31:0] p4, tgt, alu;
    logic [31:0] exp_pc;
    logic        exp_trap;
    logic [31:0] exp_epc, exp_mtval;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 0, 0, 2'd0, 32'h4, 32'h0, 32'h0,
                 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{0, 0, 0, 2'd1, 32'h8, 32'h44, 32'h0,
                 32'h44, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{1, 1, 0, 2'd1, 32'h48, 32'h46, 32'h0,
                 32'h100, 1'b1, 32'h44, 32'h46};
    vecs[3]  = '{0, 2, 0, 2'd2, 32'h104, 32'h0, 32'h2003,
                 32'h100, 1'b1, 32'h100, 32'h2002};
    vecs[4]  = '{0, 0, 1, 2'd2, 32'h104, 32'h3, 32'h2001,
                 32'h2000, 1'b0, 32'h100, 32'h2002};
    vecs[5]  = '{0, 0, 2, 2'd3, 32'h2004, 32'h2, 32'h3,
                 32'h2004, 1'b0, 32'h100, 32'h2002};
    vecs[6]  = '{0, 0, 0, 2'd0, 32'hFFFF_FFFC, 32'h1, 32'h1,
                 32'hFFFF_FFFC, 1'b0, 32'h100, 32'h2002};
    vecs[7]  = '{0, 0, 0, 2'd0, 32'h0, 32'h1, 32'h1,
                 32'h0, 1'b0, 32'h100, 32'h2002};
    vecs[8]  = '{0, 0, 0, 2'd1, 32'h4, 32'h10, 32'h0,
                 32'h10, 1'b0, 32'h100, 32'h2002};
    vecs[9]  = '{3, 0, 0, 2'd2, 32'h14, 32'h2, 32'h11,
                 32'h10, 1'b0, 32'h100, 32'h2002};
    vecs[10] = '{0, 0, 0, 2'd2, 32'h14, 32'h2, 32'h7,
                 32'h100, 1'b1, 32'h10, 32'h6};

    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; PCSrc = 2'd0;
    PCPlus4 = 32'h0; PCTarget = 32'h0; ALUResult = 32'h0;
    mpc = 32'h0; minstr = 32'h0; mepc = 32'h0; mtval = 32'h0;
    mpend = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rst_ivalid", 32'(instr_valid), 32'd0);
    chk("rst_trap", 32'(misaligned_trap), 32'd0);
    chk_arch("rst");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_instr(vecs[i].nreq, vecs[i].nrsp, vecs[i].nstall, vecs[i].src,
               vecs[i].p4, vecs[i].tgt, vecs[i].alu, $urandom);
      chk($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
      chk($sformatf("vec%0d_trap", i), 32'(misaligned_trap),
          32'(vecs[i].exp_trap));
      chk($sformatf("vec%0d_epc", i), epc_out, vecs[i].exp_epc);
      chk($sformatf("vec%0d_mtval", i), mtval_out, vecs[i].exp_mtval);
    end

    for (int n = 0; n < 300; n++) begin
      logic [31:0] t;
      t = $urandom & ~32'd3;
      if ($urandom_range(2) == 0) t = t | 32'($urandom_range(3));
      do_instr($urandom_range(2), $urandom_range(2), $urandom_range(2),
               2'($urandom), mpc + 32'd4, t, $urandom, $urandom);
    end

    // force a trap so epc/mtval are non-reset before the reset test
    do_instr(0, 0, 0, 2'd1, mpc + 32'd4, 32'h0000_1236, 32'h0,
             32'hCAFE_F00D);
    chk("pre_rst_mtval", mtval_out, 32'h1236);
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("pre_rst_wait", 32'(imem_req_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", PC, 32'h0);
    chk("arst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("arst_ivalid", 32'(instr_valid), 32'd0);
    chk("arst_instr", Instr, 32'h0);
    chk("arst_epc", epc_out, 32'h0);
    chk("arst_mtval", mtval_out, 32'h0);
    chk("arst_trap", 32'(misaligned_trap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stale_instr", Instr, 32'h0);
      chk("stale_req_valid", 32'(imem_req_valid), 32'd1);
      chk("stale_ivalid", 32'(instr_valid), 32'd0);
    end
    mpc = 32'h0; minstr = 32'h0; mepc = 32'h0; mtval = 32'h0;
    mpend = 1'b0;
    do_instr(0, 0, 0, 2'd0, 32'h4, 32'h0, 32'h0, 32'h1234_5678);
    chk("post_rst_pc", PC, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter register and instruction-fetch sequencer feeding the PC adder and instruction memory. Holds the architectural PC, issues one fetch request per instruction over a valid/ready handshake, captures the returned word, and selects the next PC (sequential, branch/JAL target, JALR target, or trap vector) once the datapath releases the instruction. Sits directly upstream of the PC+4 adder: its `PC` output drives the adder, and the adder's `PCPlus4` comes back as the sequential next-PC candidate.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned-target trap
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- PCPlus4  in  32  sequential next PC from the PC adder
- PCTarget  in  32  branch/JAL target
- ALUResult  in  32  JALR target, before masking
- PCSrc  in  2  next-PC select: 00 PCPlus4, 01 PCTarget, 10 ALUResult & ~1, 11 reserved (treated as 00)
- stall  in  1  datapath hold; freezes the EXEC state
- PC  out  32  current PC; also the fetch address
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  fetch data valid
- imem_rdata  in  32  fetched word
- Instr  out  32  captured instruction
- instr_valid  out  1  Instr is valid for the datapath; gates all architectural writes
- misaligned_trap  out  1  one-cycle pulse on trap entry
- epc_out  out  32  PC of the instruction that trapped
- mtval_out  out  32  faulting target address

## Operation
- Three-state FSM: REQ, WAIT, EXEC.
- REQ: imem_req_valid=1, address=PC. If imem_req_ready=1, go to WAIT. Otherwise stay in REQ and hold PC stable.
- WAIT: imem_req_valid=0. If imem_rsp_valid=1, capture imem_rdata into Instr and go to EXEC. Responses outside WAIT are ignored.
- EXEC: instr_valid=1.
  - stall=1: stay in EXEC with PC and Instr unchanged.
  - stall=0: compute the candidate next PC from PCSrc.
    - Candidate bits[1:0]==00: PC <= candidate, go to REQ.
    - Candidate bits[1:0]!=00: PC <= TRAP_VECTOR, epc_out <= PC, mtval_out <= candidate, set misaligned_trap for the next cycle, go to REQ.
- Candidate alignment:
  - JALR candidate is always masked with ~1 first, so only bit1 can fault.
  - PCPlus4 alignment is guaranteed because PC is always aligned.
- The memory must present a response no earlier than the cycle after the request was accepted, and exactly one response per request.
- Instr keeps its last value outside EXEC; only instr_valid qualifies it.
- epc_out and mtval_out keep their values until the next trap.
- PC arithmetic is 32-bit modulo. Candidate 32'hFFFF_FFFC + 4 wraps to 0 with no fault.

## Timing
- Reset (async assert, any state): state=REQ, PC=RESET_VECTOR, Instr=0, instr_valid=0, misaligned_trap=0, epc_out=0, mtval_out=0, imem_req_valid=1 (Moore output of REQ).
- Instruction memory shares rst_n, so any outstanding response is discarded by both sides.
- Minimum 3 cycles per instruction: REQ(accept) -> WAIT(rsp) -> EXEC(stall=0). PC updates on the EXEC->REQ edge.
- Each cycle of imem_req_ready=0, imem_rsp_valid=0 in WAIT, or stall=1 adds exactly one cycle.
- instr_valid and imem_req_valid are registered-state decodes, glitch-free, never both high.
- misaligned_trap is high only in the first REQ cycle after trap entry. It is not held by backpressure.

## Test plan
- Reset release, ready=1, rsp one cycle later: PC=0 in REQ, instr_valid high in cycle 2; with PCSrc=00, PC=4 in cycle 3, with an identical sequence following.
- Backpressure: req_ready low 3 cycles at PC=0x10 -> imem_req_valid stays 1, PC stays 0x10, accept on 4th cycle, WAIT entered next.
- Stall: stall=1 for 2 EXEC cycles, PCPlus4 changing -> PC and Instr frozen, instr_valid stays 1, PC loads the PCPlus4 value present when stall drops.
- JALR: PCSrc=10, ALUResult=0x0000_2003 -> candidate 0x2002 -> misaligned_trap pulses, PC=0x100, epc_out=old PC, mtval_out=0x2002. ALUResult=0x2001 -> PC=0x2000, no trap.
- Branch misaligned: PCSrc=01, PCTarget=0x0000_0046 -> trap with mtval_out=0x46. PCTarget=0x44 -> PC=0x44, no trap.
- Reset mid-WAIT: assert rst_n low while waiting -> outputs return to reset values immediately (asynchronously). A stale rsp_valid after release while in REQ is ignored, and Instr stays 0.
